// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: predictor table clear sweep plus update queue.
// Ports: clk, reset (async low); upd_* EX handshake; flush_req;
//   tbl_* table write port; ghr, pred_enable, busy status.
// Macro BP_GSHARE_HASH_EN: index = pc bits XOR global history.
module bp_update_ctrl #(
  parameter int IDX_W  = 5,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic              upd_taken,
  input  logic              upd_is_jal,
  input  logic              flush_req,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_idx,
  output logic [29-IDX_W:0] tbl_tag,
  output logic [31:0]       tbl_target,
  output logic              tbl_taken,
  output logic              tbl_clear,
  output logic [IDX_W-1:0]  ghr,
  output logic              pred_enable,
  output logic              busy
);

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DRAIN_FLUSH
  } state_t;

  localparam int PW = $clog2(QDEPTH);

  state_t state, state_nxt;
  logic [IDX_W-1:0] sweep, sweep_nxt;
  logic [PW:0] wptr, rptr;
  logic [PW-1:0] wa, ra;

  logic [31:0]      q_pc  [QDEPTH];
  logic [31:0]      q_tgt [QDEPTH];
  logic             q_tkn [QDEPTH];
  logic [IDX_W-1:0] q_idx [QDEPTH];

  logic empty, full, accept, pop, taken_eff;
  logic [IDX_W-1:0] new_idx;
  logic [31:0] head_pc;
  logic unused_pc;

  assign wa = wptr[PW-1:0];
  assign ra = rptr[PW-1:0];
  // extra pointer bit tells full from empty
  assign empty = (wptr == rptr);
  assign full = (wptr[PW] != rptr[PW]) && (wa == ra);
  assign taken_eff = upd_taken | upd_is_jal;
  assign new_idx = upd_pc[IDX_W+1:2] ^ ghr;
  assign head_pc = q_pc[ra];
  assign unused_pc = ^head_pc[IDX_W+1:0];
  assign accept = upd_valid & upd_ready;

`ifdef BP_GSHARE_HASH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr <= '0;
    end else if (state == DRAIN_FLUSH) begin
      ghr <= '0;
    end else if (accept) begin
      ghr <= {ghr[IDX_W-2:0], taken_eff};
    end
  end
`else
  assign ghr = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      sweep <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
      if (state == DRAIN_FLUSH) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (accept) wptr <= wptr + 1'b1;
        if (pop)    rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_pc[wa]  <= upd_pc;
      q_tgt[wa] <= upd_target;
      q_tkn[wa] <= taken_eff;
      q_idx[wa] <= new_idx;
    end
  end

  always_comb begin
    state_nxt   = state;
    sweep_nxt   = sweep;
    upd_ready   = 1'b0;
    pred_enable = 1'b0;
    busy        = 1'b1;
    pop         = 1'b0;
    tbl_we      = 1'b0;
    tbl_clear   = 1'b0;
    tbl_idx     = '0;
    tbl_tag     = '0;
    tbl_target  = '0;
    tbl_taken   = 1'b0;
    unique case (state)
      CLEAR: begin
        // no table writes while reset is held
        tbl_we    = reset;
        tbl_clear = reset;
        tbl_idx   = reset ? sweep : '0;
        if (flush_req) begin
          sweep_nxt = '0;
        end else if (&sweep) begin
          sweep_nxt = '0;
          state_nxt = RUN;
        end else begin
          sweep_nxt = sweep + IDX_W'(1);
        end
      end
      RUN: begin
        pred_enable = 1'b1;
        busy        = !empty;
        if (flush_req) begin
          state_nxt = DRAIN_FLUSH;
        end else begin
          pop = !empty;
          // a pop frees the slot a full-queue accept lands in
          upd_ready = !full || pop;
          if (pop) begin
            tbl_we     = 1'b1;
            tbl_idx    = q_idx[ra];
            tbl_tag    = head_pc[31:IDX_W+2];
            tbl_target = q_tgt[ra];
            tbl_taken  = q_tkn[ra];
          end
        end
      end
      DRAIN_FLUSH: begin
        state_nxt = CLEAR;
        sweep_nxt = '0;
      end
      default: begin
        state_nxt = CLEAR;
        sweep_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed bench for bp_update_ctrl.
// Expected values are hand-computed for IDX_W=5, QDEPTH=4.
module tb_bp_update_ctrl;

`ifdef BP_GSHARE_HASH_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_jal;
  logic        flush_req;
  logic        tbl_we;
  logic [4:0]  tbl_idx;
  logic [24:0] tbl_tag;
  logic [31:0] tbl_target;
  logic        tbl_taken;
  logic        tbl_clear;
  logic [4:0]  ghr;
  logic        pred_enable;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int we_cnt;

  logic [31:0] v_pc  [5];
  logic [31:0] v_tgt [5];
  logic        v_tkn [5];
  logic        v_jal [5];
  logic [4:0]  v_ing [5];
  logic [4:0]  v_igs [5];
  logic [24:0] v_tag [5];
  logic        v_out [5];

  bp_update_ctrl dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_is_jal(upd_is_jal),
    .flush_req(flush_req),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_tag(tbl_tag),
    .tbl_target(tbl_target), .tbl_taken(tbl_taken),
    .tbl_clear(tbl_clear), .ghr(ghr),
    .pred_enable(pred_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_chk(input string tag);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk({tag, "_clr"}, {31'd0, tbl_clear}, 1);
      chk({tag, "_idx"}, {27'd0, tbl_idx}, i);
      chk({tag, "_busy"}, {31'd0, busy}, 1);
      chk({tag, "_rdy"}, {31'd0, upd_ready}, 0);
      cyc();
    end
  endtask

  initial begin
    v_pc  = '{32'h0000_0100, 32'h0000_02C8, 32'h8000_0010,
              32'hFFFF_FFFC, 32'h0000_0038};
    v_tgt = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008,
              32'h4444_000C, 32'h5555_0010};
    v_tkn = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    v_jal = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v_ing = '{5'h00, 5'h12, 5'h04, 5'h1F, 5'h0E};
    v_igs = '{5'h01, 5'h10, 5'h01, 5'h15, 5'h1B};
    v_tag = '{25'h2, 25'h5, 25'h100_0000, 25'h1FF_FFFF, 25'h0};
    v_out = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_target = '0;
    upd_taken = 1'b0;
    upd_is_jal = 1'b0;
    flush_req = 1'b0;

    // held in reset
    cyc();
    cyc();
    #1;
    chk("rst_we", {31'd0, tbl_we}, 0);
    chk("rst_pe", {31'd0, pred_enable}, 0);
    chk("rst_rdy", {31'd0, upd_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_ghr", {27'd0, ghr}, 0);

    // release; updates offered during sweep must be ignored
    cyc();
    reset = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h0000_0044;
    sweep_chk("sw1");
    upd_valid = 1'b0;
    #1;
    chk("run_pe", {31'd0, pred_enable}, 1);
    chk("run_rdy", {31'd0, upd_ready}, 1);
    chk("run_we", {31'd0, tbl_we}, 0);
    chk("run_busy", {31'd0, busy}, 0);

    // single update, one-cycle issue latency
    upd_valid = 1'b1;
    upd_pc = 32'h0000_0044;
    upd_target = 32'hCAFE_0040;
    upd_taken = 1'b1;
    #1;
    chk("u1_rdy", {31'd0, upd_ready}, 1);
    cyc();
    upd_valid = 1'b0;
    #1;
    chk("u1_we", {31'd0, tbl_we}, 1);
    chk("u1_clr", {31'd0, tbl_clear}, 0);
    chk("u1_idx", {27'd0, tbl_idx}, 5'b10001);
    chk("u1_tag", {7'd0, tbl_tag}, 0);
    chk("u1_tgt", tbl_target, 32'hCAFE_0040);
    chk("u1_tkn", {31'd0, tbl_taken}, 1);
    chk("u1_busy", {31'd0, busy}, 1);
    chk("u1_ghr", {27'd0, ghr}, GS ? 1 : 0);
    cyc();
    #1;
    chk("u1_idle_we", {31'd0, tbl_we}, 0);
    chk("u1_idle_idx", {27'd0, tbl_idx}, 0);
    chk("u1_idle_tgt", tbl_target, 0);
    chk("u1_idle_busy", {31'd0, busy}, 0);

    // five back-to-back updates, last one a not-taken jal
    we_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1;
      upd_pc = v_pc[k];
      upd_target = v_tgt[k];
      upd_taken = v_tkn[k];
      upd_is_jal = v_jal[k];
      #1;
      chk("b5_rdy", {31'd0, upd_ready}, 1);
      if (tbl_we) we_cnt++;
      if (k > 0) begin
        chk("b5_idx", {27'd0, tbl_idx}, GS ? v_igs[k-1] : v_ing[k-1]);
        chk("b5_tag", {7'd0, tbl_tag}, v_tag[k-1]);
        chk("b5_tgt", tbl_target, v_tgt[k-1]);
        chk("b5_tkn", {31'd0, tbl_taken}, v_out[k-1]);
      end
      cyc();
    end
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    upd_is_jal = 1'b0;
    #1;
    if (tbl_we) we_cnt++;
    chk("jal_idx", {27'd0, tbl_idx}, GS ? v_igs[4] : v_ing[4]);
    chk("jal_tkn", {31'd0, tbl_taken}, 1);
    chk("jal_tgt", tbl_target, v_tgt[4]);
    chk("jal_ghr", {27'd0, ghr}, GS ? 5'b01011 : 0);
    cyc();
    #1;
    if (tbl_we) we_cnt++;
    chk("b5_pulses", we_cnt, 5);

    // flush with an entry pending; concurrent update loses
    upd_valid = 1'b1;
    upd_pc = 32'h0000_0044;
    upd_target = 32'h0BAD_0000;
    upd_taken = 1'b1;
    cyc();
    flush_req = 1'b1;
    upd_pc = 32'h0000_0048;
    #1;
    chk("fl_rdy", {31'd0, upd_ready}, 0);
    chk("fl_we", {31'd0, tbl_we}, 0);
    chk("fl_busy", {31'd0, busy}, 1);
    chk("fl_ghr", {27'd0, ghr}, GS ? 5'b10111 : 0);
    cyc();
    flush_req = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("dr_we", {31'd0, tbl_we}, 0);
    chk("dr_pe", {31'd0, pred_enable}, 0);
    chk("dr_rdy", {31'd0, upd_ready}, 0);
    chk("dr_busy", {31'd0, busy}, 1);
    cyc();
    #1;
    chk("fl_ghr0", {27'd0, ghr}, 0);
    sweep_chk("sw2");
    #1;
    chk("sw2_pe", {31'd0, pred_enable}, 1);
    chk("sw2_busy", {31'd0, busy}, 0);
    chk("sw2_we", {31'd0, tbl_we}, 0);

    // flush during sweep restarts at 0
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) cyc();
    flush_req = 1'b1;
    #1;
    chk("cf_idx5", {27'd0, tbl_idx}, 5);
    cyc();
    flush_req = 1'b0;
    #1;
    chk("cf_idx0", {27'd0, tbl_idx}, 0);
    chk("cf_clr", {31'd0, tbl_clear}, 1);

    // reset at sweep index 17
    for (int i = 0; i < 17; i++) cyc();
    #1;
    chk("mr_idx17", {27'd0, tbl_idx}, 17);
    reset = 1'b0;
    #1;
    chk("mr_we", {31'd0, tbl_we}, 0);
    chk("mr_idx", {27'd0, tbl_idx}, 0);
    chk("mr_busy", {31'd0, busy}, 1);
    chk("mr_pe", {31'd0, pred_enable}, 0);
    cyc();
    cyc();
    reset = 1'b1;
    sweep_chk("sw3");
    #1;
    chk("sw3_pe", {31'd0, pred_enable}, 1);
    chk("sw3_rdy", {31'd0, upd_ready}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 5, meaning predictor table index width (2^IDX_W entries).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning update queue depth (power of two, at least 2).
REQ-003 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- upd_valid  in  1  EX stage presents a resolved branch or jal
- upd_ready  out  1  queue can accept an update
- upd_pc  in  32  resolved instruction PC
- upd_target  in  32  resolved target
- upd_taken  in  1  actual outcome (jal counts as taken)
- upd_is_jal  in  1  instruction is jal
- flush_req  in  1  pulse; clear the whole predictor
- tbl_we  out  1  table write strobe
- tbl_idx  out  IDX_W  table write index
- tbl_tag  out  32-IDX_W-2  tag, equal to pc[31:IDX_W+2]
- tbl_target  out  32  BTB target
- tbl_taken  out  1  outcome to apply
- tbl_clear  out  1  write clears the entry (valid=0, counter=00)
- ghr  out  IDX_W  global history, used by the lookup hash
- pred_enable  out  1  lookup predictions may be used
- busy  out  1  clearing sweep in progress or queue not empty

Function
REQ-004 SHALL implement the states CLEAR, RUN and DRAIN_FLUSH.
REQ-005 In CLEAR, the block SHALL assert tbl_we=1 and tbl_clear=1 each cycle with tbl_idx counting 0 to 2^IDX_W-1, then enter RUN on the cycle after the last index; the sweep SHALL take exactly 2^IDX_W cycles.
REQ-006 In CLEAR, the block SHALL hold pred_enable=0 and upd_ready=0, and SHALL ignore upd_valid.
REQ-007 In RUN, pred_enable SHALL be 1.
REQ-008 An update is accepted on a rising clk edge where upd_valid and upd_ready are both 1.
REQ-009 upd_ready SHALL be 1 in RUN when the queue is not full.
REQ-010 The queue SHALL be a circular FIFO with QDEPTH entries; read and write pointers SHALL wrap modulo QDEPTH.
REQ-011 Each accepted entry SHALL store pc, target, taken, and the computed index.
REQ-012 The index SHALL be computed at accept time from the ghr value at that edge.
REQ-013 When the queue is non-empty in RUN, the block SHALL issue the head entry with tbl_we=1 and tbl_clear=0, and pop it, at one entry per cycle.
REQ-014 Issue latency SHALL be one cycle: an entry accepted at edge N into an empty queue appears on tbl_* during cycle N+1.
REQ-015 A simultaneous accept and pop SHALL leave occupancy unchanged, and SHALL be legal when the queue is full because the pop frees a slot in the same cycle.
REQ-016 The tbl_taken written for a jal entry SHALL be 1 regardless of upd_taken.
REQ-017 On accept, ghr SHALL become {ghr[IDX_W-2:0], taken_eff}, where taken_eff = upd_taken | upd_is_jal.
REQ-018 When tbl_we=0, the outputs tbl_idx, tbl_tag, tbl_target and tbl_taken SHALL be 0.
REQ-019 A flush_req in RUN SHALL move the block to DRAIN_FLUSH.
REQ-020 In DRAIN_FLUSH, upd_ready=0 and pred_enable=0; the block SHALL discard all queued entries without writing them, reset ghr to 0, and enter CLEAR on the next cycle.
REQ-021 A flush_req received during CLEAR SHALL restart the sweep at index 0.
REQ-022 An upd_valid and a flush_req in the same cycle SHALL result in the flush winning: the update is not accepted.
REQ-023 busy SHALL be 1 in CLEAR and DRAIN_FLUSH, and in RUN while the queue is non-empty.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force state=CLEAR, sweep index 0, queue empty, ghr 0, tbl_we 0, pred_enable 0, upd_ready 0, and busy 1.
REQ-025 The sweep SHALL begin on the first rising edge after reset rises.
REQ-026 A reset asserted mid-sweep or mid-drain SHALL abandon the operation and restart per REQ-024.

Configuration
REQ-027 With macro BP_GSHARE_HASH_EN defined, the index SHALL be upd_pc[IDX_W+1:2] XOR ghr, and ghr SHALL update per REQ-017.
REQ-028 Without BP_GSHARE_HASH_EN, the index SHALL be upd_pc[IDX_W+1:2], ghr SHALL be held at 0, and all other behaviour SHALL be unchanged.

Verification
REQ-029 Reset release -> tbl_clear=1 for 32 cycles with idx 0..31; pred_enable=1 and upd_ready=1 on cycle 33.
REQ-030 With the macro on and ghr=00000, accept pc=0x0000_0044, taken=1 -> next cycle tbl_we=1, idx=10001, tag=0x0000_0, target echoed; ghr=00001.
REQ-031 Hold tbl_* drain off by sending 5 back-to-back updates in 5 cycles -> all accepted in order, upd_ready never 0, tbl_we pulses 5 times.
REQ-032 flush_req with 3 entries queued -> no further non-clear writes; ghr=0; a 32-cycle sweep follows; busy=1 throughout.
REQ-033 jal with upd_taken=0 -> tbl_taken=1 and ghr LSB=1.
REQ-034 Assert reset low at sweep index 17 -> outputs reset immediately; after release the sweep restarts at 0.
